spi_lcd_receiver: RTL and testbench
===================================

SPI_LCD_RECEIVER -- requirements
Module: spi_lcd_receiver

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, received-byte FIFO entries (power of two, 2..16).
REQ-002 clk  input  1  system clock; must be at least 4x spi_clk frequency.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 spi_clk  input  1  SPI serial clock from controller, idle low (mode 0), asynchronous to clk.
REQ-005 spi_mosi  input  1  serial data, MSB first, asynchronous.
REQ-006 spi_cs_n  input  1  chip select, active low, asynchronous.
REQ-007 lcd_dc  input  1  data/command flag (1 = data, 0 = command), asynchronous.
REQ-008 rx_valid  output  1  FIFO head holds a byte.
REQ-009 rx_data  output  8  byte at FIFO head.
REQ-010 rx_dc  output  1  lcd_dc value captured with rx_data.
REQ-011 rx_ready  input  1  consumer accepts head when rx_valid && rx_ready.
REQ-012 busy  output  1  synchronized spi_cs_n is low.
REQ-013 byte_count  output  16  bytes completed in current CS-low transaction.
REQ-014 overflow  output  1  sticky: byte dropped because FIFO was full.
REQ-015 frame_error  output  1  sticky: CS deasserted with a partial byte.
REQ-016 clear_errors  input  1  synchronous pulse clearing overflow and frame_error.

Function
REQ-017 spi_clk, spi_mosi, spi_cs_n, lcd_dc shall each pass through a 2-flop synchronizer; all logic shall use synchronized values only.
REQ-018 A third register stage on spi_clk and spi_cs_n shall provide edge detection; an edge appears as a one-cycle pulse 3 clk cycles after the pin edge.
REQ-019 States: IDLE (CS high), SHIFT (CS low).
REQ-020 IDLE -> SHIFT on synchronized CS falling edge: bit counter = 0, shift register = 0, byte_count = 0.
REQ-021 SHIFT: on each spi_clk rising-edge pulse, shift synchronized mosi into LSB, increment 3-bit bit counter.
REQ-022 Falling spi_clk edges, and all spi_clk edges in IDLE, shall be ignored.
REQ-023 On the 8th rising-edge pulse (cycle N), the byte {shift[6:0], mosi} and synchronized lcd_dc shall be pushed at end of cycle N; bit counter wraps to 0; byte_count increments, saturating at 16'hFFFF.
REQ-024 If the FIFO was empty, rx_valid shall be 1 in cycle N+1 with the new byte on rx_data/rx_dc (show-ahead).
REQ-025 Pop occurs on any cycle with rx_valid && rx_ready; the next entry, if any, shall appear the following cycle.
REQ-026 Push while full with no simultaneous pop: byte dropped, FIFO unchanged, overflow set next cycle.
REQ-027 Push while full with simultaneous pop: both performed, no overflow.
REQ-028 SHIFT -> IDLE on synchronized CS rising edge; if bit counter != 0, partial byte discarded and frame_error set; byte_count holds its value until next CS falling edge.
REQ-029 clear_errors clears both sticky flags next cycle; a new error event in the same cycle wins (flag stays/becomes 1).
REQ-030 rx_data/rx_dc shall be stable while rx_valid && !rx_ready.
REQ-031 FIFO pointers shall wrap modulo FIFO_DEPTH; full/empty distinguished by an extra pointer bit or occupancy counter.

Reset
REQ-032 reset_n low shall asynchronously set: state IDLE, synchronizers to idle (spi_clk 0, cs_n 1, mosi 0, dc 0), FIFO empty, rx_valid 0, rx_data 8'h00, rx_dc 0, busy 0, byte_count 0, overflow 0, frame_error 0.
REQ-033 Reset mid-transaction: the partial byte is lost and no frame_error is raised; after release, reception resumes only after a new CS falling edge.

Verification
REQ-034 CS low, lcd_dc=0, send 8'h2A, rx_ready=1 -> one cycle rx_valid with rx_data=8'h2A, rx_dc=0; byte_count=1.
REQ-035 CS low, send 8'hA5 (dc=1) then 8'h3C (dc=0), rx_ready=0 -> rx_valid held, head 8'hA5/dc 1; after one pop, head 8'h3C/dc 0; byte_count=2.
REQ-036 FIFO_DEPTH=4, rx_ready=0, send 5 bytes 8'h01..8'h05 -> overflow=1, pops return 01,02,03,04 only.
REQ-037 Send 5 spi_clk bits then raise CS -> no push, frame_error=1; clear_errors pulse -> frame_error=0 next cycle.
REQ-038 Assert reset_n=0 after 3 bits of a byte, release, new CS-low transaction sending 8'hC3 -> rx_data=8'hC3, frame_error=0, byte_count=1.
REQ-039 Toggle spi_clk 16 times with CS high -> rx_valid stays 0, byte_count unchanged, busy=0.

Source files
------------

// File: rtl/spi_lcd_receiver.sv
// SPI mode-0 receiver for an LCD controller front end.
// Every pin is treated as asynchronous and is resynchronised into clk before use.
// Each received byte is stored together with its data/command flag in a show-ahead FIFO.
//
// State table
//   state    | meaning
//   ST_IDLE  | chip select is high; spi_clk edges are ignored
//   ST_SHIFT | chip select is low; rising spi_clk edges shift mosi into the byte
module spi_lcd_receiver #(
   parameter int FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        spi_clk,
   input  logic        spi_mosi,
   input  logic        spi_cs_n,
   input  logic        lcd_dc,
   output logic        rx_valid,
   output logic [7:0]  rx_data,
   output logic        rx_dc,
   input  logic        rx_ready,
   output logic        busy,
   output logic [15:0] byte_count,
   output logic        overflow,
   output logic        frame_error,
   input  logic        clear_errors
);

   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

   // Synchronizer chains. Bit 0 is the first flop.
   // Bit 2 is the extra stage used for edge detection.
   logic [2:0] sclk_sync_q;
   logic [2:0] cs_sync_q;
   logic [1:0] mosi_sync_q;
   logic [1:0] dc_sync_q;

   state_t      state_q, state_d;
   logic [2:0]  bit_cnt_q, bit_cnt_d;
   logic [6:0]  shift_q, shift_d;
   logic [15:0] byte_count_q, byte_count_d;
   logic        overflow_q, frame_error_q;

   logic [8:0]  fifo_mem [FIFO_DEPTH];
   logic [AW:0] wr_ptr_q, rd_ptr_q;

   logic sclk_rise, cs_fall, cs_rise, mosi_s, dc_s;
   logic push, pop, push_ok, ovf_evt, fe_evt;
   logic fifo_empty, fifo_full;
   logic [7:0] push_byte;

   // Two-flop synchronizers, plus a third stage on the clock and chip-select chains.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sclk_sync_q <= 3'b000;
         cs_sync_q   <= 3'b111;
         mosi_sync_q <= 2'b00;
         dc_sync_q   <= 2'b00;
      end else begin
         sclk_sync_q <= {sclk_sync_q[1:0], spi_clk};
         cs_sync_q   <= {cs_sync_q[1:0], spi_cs_n};
         mosi_sync_q <= {mosi_sync_q[0], spi_mosi};
         dc_sync_q   <= {dc_sync_q[0], lcd_dc};
      end
   end

   assign sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];
   assign cs_fall   = ~cs_sync_q[1] & cs_sync_q[2];
   assign cs_rise   = cs_sync_q[1] & ~cs_sync_q[2];
   assign mosi_s    = mosi_sync_q[1];
   assign dc_s      = dc_sync_q[1];
   assign busy      = ~cs_sync_q[1];

   assign push_byte = {shift_q, mosi_s};

   // Register the FSM state, the bit counter, the shift register and the byte counter.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= ST_IDLE;
         bit_cnt_q    <= 3'd0;
         shift_q      <= 7'd0;
         byte_count_q <= 16'd0;
      end else begin
         state_q      <= state_d;
         bit_cnt_q    <= bit_cnt_d;
         shift_q      <= shift_d;
         byte_count_q <= byte_count_d;
      end
   end

   // Next-state logic for the FSM.
   // A chip-select rise takes priority over a clock edge in the same cycle.
   always_comb begin
      state_d      = state_q;
      bit_cnt_d    = bit_cnt_q;
      shift_d      = shift_q;
      byte_count_d = byte_count_q;
      push         = 1'b0;
      fe_evt       = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (cs_fall) begin
               state_d      = ST_SHIFT;
               bit_cnt_d    = 3'd0;
               shift_d      = 7'd0;
               byte_count_d = 16'd0;
            end
         end
         ST_SHIFT: begin
            if (cs_rise) begin
               state_d = ST_IDLE;
               fe_evt  = (bit_cnt_q != 3'd0);
            end else if (sclk_rise) begin
               shift_d   = {shift_q[5:0], mosi_s};
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) begin
                  push = 1'b1;
                  if (byte_count_q != 16'hFFFF) begin
                     byte_count_d = byte_count_q + 16'd1;
                  end
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // FIFO bookkeeping. An extra pointer bit distinguishes a full FIFO from an empty one.
   assign fifo_empty = (wr_ptr_q == rd_ptr_q);
   assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign pop        = ~fifo_empty & rx_ready;
   assign push_ok    = push & (~fifo_full | pop);
   assign ovf_evt    = push & fifo_full & ~pop;

   // FIFO storage. It is not reset: the output is masked while the FIFO is empty.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         fifo_mem[wr_ptr_q[AW-1:0]] <= {dc_s, push_byte};
      end
   end

   // FIFO pointers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
      end
   end

   // Sticky error flags. An event in the same cycle as clear_errors wins.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         overflow_q    <= 1'b0;
         frame_error_q <= 1'b0;
      end else begin
         overflow_q    <= ovf_evt | (overflow_q & ~clear_errors);
         frame_error_q <= fe_evt | (frame_error_q & ~clear_errors);
      end
   end

   assign rx_valid    = ~fifo_empty;
   assign rx_data     = fifo_empty ? 8'h00 : fifo_mem[rd_ptr_q[AW-1:0]][7:0];
   assign rx_dc       = fifo_empty ? 1'b0  : fifo_mem[rd_ptr_q[AW-1:0]][8];
   assign byte_count  = byte_count_q;
   assign overflow    = overflow_q;
   assign frame_error = frame_error_q;

endmodule

// File: tb/tb_spi_lcd_receiver.sv
// Testbench for spi_lcd_receiver.
// A byte-level scoreboard model is checked against the FIFO output at every pop.
module tb_spi_lcd_receiver;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        spi_clk = 1'b0;
   logic        spi_mosi = 1'b0;
   logic        spi_cs_n = 1'b1;
   logic        lcd_dc = 1'b0;
   logic        rx_ready = 1'b0;
   logic        clear_errors = 1'b0;
   logic        rx_valid;
   logic [7:0]  rx_data;
   logic        rx_dc;
   logic        busy;
   logic [15:0] byte_count;
   logic        overflow;
   logic        frame_error;

   spi_lcd_receiver #(.FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .reset_n(reset_n), .spi_clk(spi_clk), .spi_mosi(spi_mosi),
      .spi_cs_n(spi_cs_n), .lcd_dc(lcd_dc), .rx_valid(rx_valid), .rx_data(rx_data),
      .rx_dc(rx_dc), .rx_ready(rx_ready), .busy(busy), .byte_count(byte_count),
      .overflow(overflow), .frame_error(frame_error), .clear_errors(clear_errors)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Scoreboard state: bytes the DUT should hold, in order, as {dc, data}.
   logic [8:0] exp_q[$];
   int         exp_bc = 0;
   logic       exp_ovf = 1'b0;
   logic       exp_fe = 1'b0;
   int         bit_pos = 0;
   logic [7:0] cur_byte = 8'h00;

   // Consumer control: 0 = pop only pops_pending entries, 1 = random ready, 2 = always ready.
   int ready_mode = 0;
   int pops_pending = 0;
   int valid_cycles = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Consumer and pop checker. Ready is chosen on the falling edge, and the pop it
   // causes on the next rising edge is checked against the model at the same time.
   initial begin
      logic [8:0] e;
      forever begin
         @(negedge clk);
         if (rx_valid) valid_cycles++;
         case (ready_mode)
            1:       rx_ready = ($urandom_range(0, 1) == 1);
            2:       rx_ready = 1'b1;
            default: rx_ready = (pops_pending > 0);
         endcase
         if (rx_valid && rx_ready && reset_n) begin
            if (exp_q.size() == 0) begin
               chk("pop_extra", {23'd0, rx_dc, rx_data}, 32'hFFFF_FFFF);
            end else begin
               e = exp_q.pop_front();
               chk("pop_byte", {23'd0, rx_dc, rx_data}, {23'd0, e});
               if (pops_pending > 0) pops_pending--;
            end
         end
      end
   end

   initial begin
      #3ms;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic wait_clk(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Sends one mode-0 bit. The model is updated before the rising edge, so an
   // expected byte is already queued by the time the DUT can present it.
   task automatic send_bit(input logic b);
      spi_mosi = b;
      wait_clk(4);
      cur_byte = {cur_byte[6:0], b};
      if (bit_pos == 7) begin
         exp_bc = (exp_bc == 65535) ? exp_bc : exp_bc + 1;
         if (exp_q.size() < DEPTH) exp_q.push_back({lcd_dc, cur_byte});
         else exp_ovf = 1'b1;
      end
      bit_pos = (bit_pos + 1) % 8;
      spi_clk = 1'b1;
      wait_clk(4);
      spi_clk = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] d, input logic dc);
      lcd_dc = dc;
      for (int i = 7; i >= 0; i--) send_bit(d[i]);
   endtask

   task automatic cs_low();
      spi_cs_n = 1'b0;
      exp_bc = 0;
      bit_pos = 0;
      wait_clk(4);
   endtask

   task automatic cs_high();
      wait_clk(2);
      spi_cs_n = 1'b1;
      if (bit_pos != 0) exp_fe = 1'b1;
      bit_pos = 0;
      wait_clk(6);
   endtask

   task automatic pulse_clear();
      clear_errors = 1'b1;
      wait_clk(1);
      clear_errors = 1'b0;
      exp_fe = 1'b0;
      exp_ovf = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 400 && exp_q.size() != 0; i++) wait_clk(1);
      chk("drain_empty", 32'(exp_q.size()), 32'd0);
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      spi_cs_n = 1'b1;
      spi_clk = 1'b0;
      spi_mosi = 1'b0;
      lcd_dc = 1'b0;
      exp_q.delete();
      exp_bc = 0;
      exp_ovf = 1'b0;
      exp_fe = 1'b0;
      bit_pos = 0;
      pops_pending = 0;
      ready_mode = 0;
      wait_clk(2);
      reset_n = 1'b1;
      wait_clk(3);
   endtask

   task automatic chk_reset_vals();
      chk("rst_valid", 32'(rx_valid), 32'd0);
      chk("rst_data", 32'(rx_data), 32'd0);
      chk("rst_dc", 32'(rx_dc), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_bc", 32'(byte_count), 32'd0);
      chk("rst_ovf", 32'(overflow), 32'd0);
      chk("rst_fe", 32'(frame_error), 32'd0);
   endtask

   initial begin
      int nb;
      int nbits;
      wait_clk(2);
      chk_reset_vals();
      do_reset();

      // One byte, command flag, consumer always ready.
      ready_mode = 2;
      valid_cycles = 0;
      cs_low();
      chk("busy_low", 32'(busy), 32'd1);
      send_byte(8'h2A, 1'b0);
      wait_clk(6);
      chk("single_valid_cycles", 32'(valid_cycles), 32'd1);
      chk("single_popped", 32'(exp_q.size()), 32'd0);
      cs_high();
      chk("single_bc", 32'(byte_count), 32'(exp_bc));
      chk("single_busy", 32'(busy), 32'd0);

      // Two bytes held with the consumer stalled, then popped one at a time.
      ready_mode = 0;
      cs_low();
      send_byte(8'hA5, 1'b1);
      send_byte(8'h3C, 1'b0);
      wait_clk(6);
      chk("hold_valid", 32'(rx_valid), 32'd1);
      chk("hold_head1", {23'd0, rx_dc, rx_data}, 32'h1A5);
      wait_clk(3);
      chk("hold_stable", {23'd0, rx_dc, rx_data}, 32'h1A5);
      pops_pending = 1;
      wait_clk(3);
      chk("hold_head2", {23'd0, rx_dc, rx_data}, 32'h03C);
      chk("hold_bc", 32'(byte_count), 32'd2);
      pops_pending = 1;
      cs_high();
      drain();

      // Overflow: with the consumer stalled, the fifth byte is dropped.
      do_reset();
      cs_low();
      for (int i = 1; i <= 4; i++) send_byte(8'(i), 1'b0);
      wait_clk(6);
      chk("ovf_before", 32'(overflow), 32'(exp_ovf));
      send_byte(8'h05, 1'b1);
      wait_clk(6);
      chk("ovf_after", 32'(overflow), 32'd1);
      cs_high();
      chk("ovf_bc", 32'(byte_count), 32'(exp_bc));
      pops_pending = 4;
      drain();
      wait_clk(4);
      chk("ovf_empty", 32'(rx_valid), 32'd0);
      pulse_clear();
      chk("ovf_cleared", 32'(overflow), 32'd0);

      // Partial byte: raising chip select flags a frame error and pushes nothing.
      valid_cycles = 0;
      cs_low();
      for (int i = 0; i < 5; i++) send_bit(1'($urandom_range(0, 1)));
      cs_high();
      chk("fe_set", 32'(frame_error), 32'(exp_fe));
      chk("fe_nopush", 32'(valid_cycles), 32'd0);
      chk("fe_bc", 32'(byte_count), 32'(exp_bc));
      pulse_clear();
      chk("fe_cleared", 32'(frame_error), 32'd0);

      // Clock edges while chip select is high are ignored.
      valid_cycles = 0;
      for (int i = 0; i < 16; i++) begin
         spi_mosi = 1'($urandom_range(0, 1));
         spi_clk = ~spi_clk;
         wait_clk(4);
      end
      chk("idle_valid", 32'(valid_cycles), 32'd0);
      chk("idle_bc", 32'(byte_count), 32'(exp_bc));
      chk("idle_busy", 32'(busy), 32'd0);

      // Reset in the middle of a byte, then a clean transaction.
      cs_low();
      for (int i = 0; i < 3; i++) send_bit(1'b1);
      reset_n = 1'b0;
      wait_clk(1);
      chk_reset_vals();
      do_reset();
      ready_mode = 2;
      cs_low();
      send_byte(8'hC3, 1'b1);
      wait_clk(6);
      chk("post_rst_popped", 32'(exp_q.size()), 32'd0);
      chk("post_rst_bc", 32'(byte_count), 32'd1);
      cs_high();
      chk("post_rst_fe", 32'(frame_error), 32'd0);

      // Random transactions with a random consumer and occasional partial bytes.
      ready_mode = 1;
      for (int t = 0; t < 10; t++) begin
         nb = $urandom_range(1, 4);
         cs_low();
         for (int b = 0; b < nb; b++) send_byte(8'($urandom), 1'($urandom_range(0, 1)));
         nbits = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 7) : 0;
         for (int b = 0; b < nbits; b++) send_bit(1'($urandom_range(0, 1)));
         cs_high();
         chk("rand_bc", 32'(byte_count), 32'(exp_bc));
         chk("rand_fe", 32'(frame_error), 32'(exp_fe));
         chk("rand_busy", 32'(busy), 32'd0);
         if (exp_fe) pulse_clear();
      end
      drain();
      chk("rand_ovf", 32'(overflow), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
